// File: rtl/rom_fetch.sv
// rtl/rom_fetch.sv - sequential program-ROM read master with prefetch queue
module rom_fetch #(
    parameter int AW    = 13,
    parameter int DW    = 8,
    parameter int WAIT  = 1,
    parameter int DEPTH = 4
) (
    input  logic          CLK_I,
    input  logic          RST_N_I,
    input  logic          EN_I,
    input  logic          JMP_I,
    input  logic [AW-1:0] JMP_ADDR_I,
    output logic          CS_O,
    output logic          RD_O,
    output logic [AW-1:0] ADDR_O,
    input  logic [DW-1:0] DAT_I,
    output logic          Q_VLD_O,
    output logic [DW-1:0] Q_DAT_O,
    output logic [AW-1:0] Q_ADDR_O,
    input  logic          Q_RDY_I,
    output logic          BUSY_O
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [AW-1:0]   r_pc;
    logic [AW-1:0]   r_addr;
    logic            r_cs;
    logic [DW-1:0]   r_q_dat  [DEPTH];
    logic [AW-1:0]   r_q_addr [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [CW-1:0]   r_count;

    logic            w_done;
    logic            w_push;
    logic            w_pop;
    logic            w_start;
    logic [AW-1:0]   w_pc_inc;
    logic [CW-1:0]   w_count_after;

    // PC wraps naturally at the address width
    assign w_pc_inc      = r_pc + AW'(1);
    // occupancy after this edge's push and pop; used to reserve the next slot
    assign w_count_after = r_count + CW'(1) - CW'(w_pop);

    // State register
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state: a jump always drops back to IDLE
    always_comb begin
        w_state_nxt = r_state;
        if (JMP_I) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_start) w_state_nxt = S_ACC;
                S_ACC:   if (w_done && !w_start) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Control strobes: access completion, push, pop and (re)start of an access
    always_comb begin
        w_done  = 1'b0;
        w_push  = 1'b0;
        w_start = 1'b0;
        w_pop   = (r_count != '0) && Q_RDY_I && !JMP_I;
        case (r_state)
            S_IDLE: w_start = EN_I && !JMP_I && (r_count < CW'(DEPTH));
            S_ACC: begin
                w_done  = (r_cnt == 4'(WAIT));
                w_push  = w_done && !JMP_I;
                w_start = w_push && EN_I && (w_count_after < CW'(DEPTH));
            end
            default: w_start = 1'b0;
        endcase
    end

    // ROM bus, wait counter and fetch PC
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_cs   <= 1'b0;
            r_addr <= '0;
            r_pc   <= '0;
            r_cnt  <= '0;
        end else if (JMP_I) begin
            r_cs <= 1'b0;
            r_pc <= JMP_ADDR_I;
        end else begin
            if (w_push) r_pc <= w_pc_inc;
            if (w_start) begin
                r_cs   <= 1'b1;
                r_cnt  <= '0;
                // back-to-back start uses the PC that advances on this same edge
                r_addr <= w_done ? w_pc_inc : r_pc;
            end else if (w_done) begin
                r_cs <= 1'b0;
            end else if (r_state == S_ACC) begin
                r_cnt <= r_cnt + 4'd1;
            end
        end
    end

    // Queue pointers and occupancy; a jump empties the queue
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (JMP_I) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + PW'(1);
            if (w_pop)  r_rptr <= r_rptr + PW'(1);
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Queue storage: captures the ROM byte with the address it was read from
    always_ff @(posedge CLK_I) begin
        if (w_push) begin
            r_q_dat[r_wptr]  <= DAT_I;
            r_q_addr[r_wptr] <= r_addr;
        end
    end

    assign CS_O     = r_cs;
    assign RD_O     = r_cs;
    assign ADDR_O   = r_addr;
    assign Q_VLD_O  = (r_count != '0);
    assign Q_DAT_O  = r_q_dat[r_rptr];
    assign Q_ADDR_O = r_q_addr[r_rptr];
    assign BUSY_O   = (r_state == S_ACC);

endmodule

// File: tb/tb_rom_fetch.sv
// tb/tb_rom_fetch.sv - scoreboard bench for rom_fetch at WAIT=1, 0 and 3
module tb_rom_fetch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [2:0]       rst_n, en, jmp, rdy, cs, rd, vld, busy;
    logic [2:0][12:0] jaddr, addr, qaddr;
    logic [2:0][7:0]  dat, qdat;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [7:0] rom(input logic [12:0] a);
        return a[7:0] ^ 8'h5A;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_mon
        localparam int WV = (g == 0) ? 1 : (g == 1) ? 0 : 3;

        assign dat[g] = cs[g] ? rom(addr[g]) : 8'h00;

        rom_fetch #(.AW(13), .DW(8), .WAIT(WV), .DEPTH(4)) u_dut (
            .CLK_I(clk), .RST_N_I(rst_n[g]), .EN_I(en[g]), .JMP_I(jmp[g]),
            .JMP_ADDR_I(jaddr[g]), .CS_O(cs[g]), .RD_O(rd[g]), .ADDR_O(addr[g]),
            .DAT_I(dat[g]), .Q_VLD_O(vld[g]), .Q_DAT_O(qdat[g]), .Q_ADDR_O(qaddr[g]),
            .Q_RDY_I(rdy[g]), .BUSY_O(busy[g])
        );

        logic [12:0] exp_q[$];
        logic [12:0] npc;
        int          pops;

        // reference: bytes leave in fetch order from the current PC, restarting on jump/reset
        initial begin
            logic [12:0] e;
            pops = 0;
            npc  = '0;
            forever begin
                @(negedge clk);
                if (!rst_n[g]) begin
                    exp_q.delete();
                    npc = '0;
                end else begin
                    while (exp_q.size() < 8) begin
                        exp_q.push_back(npc);
                        npc = npc + 13'd1;
                    end
                    if (vld[g] && rdy[g] && !jmp[g]) begin
                        e = exp_q.pop_front();
                        check($sformatf("pop_addr_w%0d", WV), 32'(qaddr[g]), 32'(e));
                        check($sformatf("pop_data_w%0d", WV), 32'(qdat[g]), 32'(rom(e)));
                        pops++;
                    end
                    if (jmp[g]) begin
                        exp_q.delete();
                        npc = jaddr[g];
                    end
                end
            end
        end
    end

    initial begin
        int rd_hi, s;
        bit found;
        logic [12:0] prev;
        rst_n = '0; en = '0; jmp = '0; rdy = '0; jaddr = '0;
        tick(2);
        check("rst_cs",   32'(cs[0]),   0);
        check("rst_rd",   32'(rd[0]),   0);
        check("rst_addr", 32'(addr[0]), 0);
        check("rst_vld",  32'(vld[0]),  0);
        check("rst_busy", 32'(busy[0]), 0);
        rst_n = 3'b111;
        tick(1);

        // fill with consumer stalled: four bytes, two RD cycles each
        en[0] = 1'b1;
        rd_hi = 0;
        for (int i = 1; i <= 20; i++) begin
            tick(1);
            if (rd[0]) rd_hi++;
            if (i == 2) check("lat_vld_early", 32'(vld[0]), 0);
            if (i == 3) check("lat_vld_due",   32'(vld[0]), 1);
        end
        check("fill_rd_cycles", rd_hi, 8);
        check("fill_cs_off", 32'(cs[0]), 0);
        check("fill_vld", 32'(vld[0]), 1);
        check("fill_head_addr", 32'(qaddr[0]), 0);
        check("fill_head_dat", 32'(qdat[0]), 32'h5A);

        // drain continuously through 0x0040 and measure steady rate
        rdy[0] = 1'b1;
        for (int i = 0; i < 300 && g_mon[0].pops < 'h41; i++) tick(1);
        check("drain_reached_0x40", 32'(g_mon[0].pops >= 'h41), 1);
        s = g_mon[0].pops;
        tick(100);
        check("steady_rate", g_mon[0].pops - s, 50);

        // jump to 0x1FFE while 0x0003 is being fetched
        rst_n[0] = 1'b0; rdy[0] = 1'b0;
        tick(1);
        rst_n[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick(1);
            if (busy[0] && addr[0] == 13'd3) found = 1;
        end
        check("jmp_found_acc3", 32'(found), 1);
        jaddr[0] = 13'h1FFE; jmp[0] = 1'b1;
        tick(1);
        jmp[0] = 1'b0;
        check("jmp_vld_cleared", 32'(vld[0]), 0);
        check("jmp_cs_cleared", 32'(cs[0]), 0);
        s = g_mon[0].pops;
        rdy[0] = 1'b1;
        tick(20);
        check("jmp_progress", 32'(g_mon[0].pops - s >= 3), 1);

        // WAIT=0: continuous strobe, address steps every cycle
        en[1] = 1'b1; rdy[1] = 1'b1;
        tick(5);
        prev = addr[1];
        for (int i = 0; i < 20; i++) begin
            tick(1);
            check("w0_rd_high", 32'(rd[1]), 1);
            check("w0_addr_step", 32'(addr[1]), 32'(13'(prev + 13'd1)));
            prev = addr[1];
        end

        // WAIT=3: enable dropped on first ACC cycle
        en[2] = 1'b1;
        tick(1);
        check("w3_busy", 32'(busy[2]), 1);
        en[2] = 1'b0;
        rd_hi = rd[2] ? 1 : 0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            if (rd[2]) rd_hi++;
        end
        check("w3_rd_cycles", rd_hi, 4);
        check("w3_cs_off", 32'(cs[2]), 0);
        check("w3_busy_off", 32'(busy[2]), 0);
        check("w3_vld", 32'(vld[2]), 1);
        rdy[2] = 1'b1;
        tick(3);
        check("w3_one_pop", g_mon[2].pops, 1);
        check("w3_empty", 32'(vld[2]), 0);
        en[2] = 1'b1;
        tick(3);
        check("w3_resume", 32'(cs[2]), 1);

        // random traffic on WAIT=1
        s = g_mon[0].pops;
        for (int i = 0; i < 800; i++) begin
            en[0]    = ($urandom % 8) != 0;
            rdy[0]   = $urandom % 2;
            jmp[0]   = !jmp[0] && (($urandom % 40) == 0);
            jaddr[0] = 13'($urandom);
            tick(1);
        end
        jmp[0] = 1'b0;
        check("rand_progress", 32'(g_mon[0].pops - s > 50), 1);

        // asynchronous reset in the middle of an access
        en[0] = 1'b1; rdy[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick(1);
            if (busy[0]) found = 1;
        end
        check("rst_mid_busy", 32'(found), 1);
        #2 rst_n[0] = 1'b0;
        #1;
        check("arst_cs",  32'(cs[0]),  0);
        check("arst_rd",  32'(rd[0]),  0);
        check("arst_vld", 32'(vld[0]), 0);
        tick(2);
        rst_n[0] = 1'b1;
        found = 0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (cs[0]) found = 1;
        end
        check("arst_restart", 32'(found), 1);
        check("arst_restart_addr", 32'(addr[0]), 0);
        s = g_mon[0].pops;
        tick(20);
        check("arst_progress", 32'(g_mon[0].pops - s >= 5), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
